// File: rtl/spi_segment_scan_controller.sv
// SPI-programmed multiplexed 7-segment scan controller with blanking between digits.
// Optional hex decoder is built when SEG_HEX_DECODE_EN is defined.
`timescale 1ns/1ps

module spi_segment_scan_controller #(
    parameter int          NUM_DIGITS   = 4,
    parameter logic [23:0] SCAN_DIV     = 24'd10_000,
    parameter logic [7:0]  BLANK_CYCLES = 8'd16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  spi_sck,
    input  logic                  spi_cs_n,
    input  logic                  spi_mosi,
    output logic [7:0]            seg_out,
    output logic [NUM_DIGITS-1:0] dig_en,
    output logic                  frame_err
);

    localparam int          DW         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [0:0]  ST_BLANK   = 1'b0;
    localparam logic [0:0]  ST_SHOW    = 1'b1;
    localparam logic [7:0]  CTRL_ADDR  = 8'h10;
    localparam logic [23:0] BLANK_LAST = {16'd0, BLANK_CYCLES} - 24'd1;
    localparam logic [23:0] SHOW_LAST  = SCAN_DIV - 24'd1;
    localparam logic [DW-1:0] D_LAST   = DW'(NUM_DIGITS - 1);

    logic sck_s1, sck_s2, sck_d;
    logic cs_s1, cs_s2, cs_d;
    logic mosi_s1, mosi_s2;

    // Synchronizers idle with cs_n high so reset release never looks like a frame end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_s1  <= 1'b0;
            sck_s2  <= 1'b0;
            sck_d   <= 1'b0;
            cs_s1   <= 1'b1;
            cs_s2   <= 1'b1;
            cs_d    <= 1'b1;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
        end else begin
            sck_s1  <= spi_sck;
            sck_s2  <= sck_s1;
            sck_d   <= sck_s2;
            cs_s1   <= spi_cs_n;
            cs_s2   <= cs_s1;
            cs_d    <= cs_s2;
            mosi_s1 <= spi_mosi;
            mosi_s2 <= mosi_s1;
        end
    end

    logic        sck_rise, cs_rise;
    logic [4:0]  bit_cnt;
    logic [14:0] shift;
    logic [15:0] frame;
    logic [7:0]  addr, data;
    logic        last_bit, addr_digit, addr_ctrl;
    logic        wr_digit, wr_ctrl, bad_addr, short_frame;

    assign sck_rise    = sck_s2 & ~sck_d;
    assign cs_rise     = cs_s2 & ~cs_d;
    // The 16th bit is taken straight from the synchronizer so the write lands in this cycle.
    assign frame       = {shift, mosi_s2};
    assign addr        = frame[15:8];
    assign data        = frame[7:0];
    assign last_bit    = ~cs_s2 & sck_rise & (bit_cnt == 5'd15);
    assign addr_digit  = addr < 8'(NUM_DIGITS);
    assign addr_ctrl   = addr == CTRL_ADDR;
    assign wr_digit    = last_bit & addr_digit;
    assign wr_ctrl     = last_bit & addr_ctrl;
    assign bad_addr    = last_bit & ~addr_digit & ~addr_ctrl;
    assign short_frame = cs_rise & (bit_cnt != 5'd0) & (bit_cnt < 5'd16);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= 5'd0;
            shift     <= 15'd0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= bad_addr | short_frame;
            if (cs_s2) begin
                bit_cnt <= 5'd0;
                shift   <= 15'd0;
            end else if (sck_rise && bit_cnt != 5'd16) begin
                bit_cnt <= bit_cnt + 5'd1;
                shift   <= {shift[13:0], mosi_s2};
            end
        end
    end

    logic [7:0] pat [NUM_DIGITS];
    logic       disp_en;
`ifdef SEG_HEX_DECODE_EN
    logic       hex_mode;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) pat[i] <= 8'h00;
            disp_en  <= 1'b1;
`ifdef SEG_HEX_DECODE_EN
            hex_mode <= 1'b0;
`endif
        end else begin
            if (wr_digit) pat[addr[DW-1:0]] <= data;
            if (wr_ctrl) begin
                disp_en  <= data[0];
`ifdef SEG_HEX_DECODE_EN
                hex_mode <= data[1];
`endif
            end
        end
    end

`ifdef SEG_HEX_DECODE_EN
    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction
`endif

    logic [0:0]            state, state_nx;
    logic [23:0]           cnt, cnt_nx;
    logic [DW-1:0]         d, d_nx;
    logic [7:0]            seg_raw, seg_val;
    logic [NUM_DIGITS-1:0] dig_nx;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + 24'd1;
        d_nx     = d;
        if (!disp_en) begin
            state_nx = ST_BLANK;
            cnt_nx   = 24'd0;
            d_nx     = '0;
        end else if (state == ST_BLANK) begin
            if (cnt == BLANK_LAST) begin
                state_nx = ST_SHOW;
                cnt_nx   = 24'd0;
            end
        end else if (cnt == SHOW_LAST) begin
            state_nx = ST_BLANK;
            cnt_nx   = 24'd0;
            d_nx     = (d == D_LAST) ? '0 : d + DW'(1);
        end
    end

    // Outputs are registered from the next state so they track the FSM with no extra lag.
    always_comb begin
        seg_raw = pat[d_nx];
        seg_val = seg_raw;
`ifdef SEG_HEX_DECODE_EN
        if (hex_mode) seg_val = {seg_raw[7], hex7(seg_raw[3:0])};
`endif
        dig_nx = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            dig_nx[i] = (state_nx == ST_SHOW) && (d_nx == DW'(i));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_BLANK;
            cnt     <= 24'd0;
            d       <= '0;
            seg_out <= 8'h00;
            dig_en  <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            d       <= d_nx;
            seg_out <= (state_nx == ST_SHOW) ? seg_val : 8'h00;
            dig_en  <= dig_nx;
        end
    end

endmodule

// File: doc/spi_segment_scan_controller.md
# spi_segment_scan_controller

SPI-programmed scan controller for a multiplexed 7-segment display. A mode-0 SPI slave writes a small register file holding per-digit segment patterns and a control byte. A scan scheduler time-shares the single segment bus across `NUM_DIGITS` digit enables, inserting a blanking gap between digits to prevent ghosting. It sits between the chip's dedicated inputs (SPI pins) and the segment/digit output pins.

## Interface
- `NUM_DIGITS`, 4: digits scanned. Legal range 1..8.
- `SCAN_DIV`, 24'd10_000: clk cycles each digit is shown. Must be ≥1.
- `BLANK_CYCLES`, 8'd16: clk cycles all digits are off before each digit. Must be ≥1.
- `clk` in 1: single system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `spi_sck` in 1: SPI clock, asynchronous to `clk`.
- `spi_cs_n` in 1: SPI chip select, active low, asynchronous.
- `spi_mosi` in 1: SPI data, asynchronous.
- `seg_out` out 8: segments {dp,g,f,e,d,c,b,a}, active high, registered.
- `dig_en` out NUM_DIGITS: one-hot or zero digit enable, active high, registered.
- `frame_err` out 1: one-cycle pulse on a rejected frame.

## Operation
- All three SPI inputs pass through 2-flop synchronizers. The sck rising edge is detected on the synchronized signal.
- **Frame format:** 16 bits, MSB first. Data is sampled on the sck rising edge while cs_n is low. Byte 0 is `addr[7:0]`, byte 1 is `data[7:0]`.
- **Address map:**
  - `0x00..NUM_DIGITS-1`: digit pattern registers, reset 0x00.
  - `0x10`: control register, reset 0x01. Bit0 = display enable. Bit1 = hex mode (see Configuration). Other bits are read-as-written and unused.
- **Commit:** a write happens exactly once per frame, in the cycle after the 16th bit is sampled.
- **Bad address:** a valid 16-bit frame to an unmapped address performs no write and pulses `frame_err`.
- **Short frame:** cs_n deasserting (synchronized) with 1..15 bits received discards the frame and pulses `frame_err`. Zero bits received is silent.
- **Long frame:** bits after the 16th are ignored until cs_n deasserts. No second write, no error.
- The bit counter and shift register clear whenever synchronized cs_n is high.
- **Scan FSM:** states BLANK and SHOW, plus a digit index `d` (0..NUM_DIGITS-1).
  - BLANK: `dig_en` = 0 and `seg_out` = 0 for BLANK_CYCLES cycles, then go to SHOW.
  - SHOW: `dig_en` = 1<<d and `seg_out` = pattern(d) for SCAN_DIV cycles. Then go to BLANK and set d = d+1, wrapping from NUM_DIGITS-1 to 0.
- **Display disabled** (ctrl bit0 = 0): the FSM is held in BLANK with d = 0 and the counter cleared, and the outputs are 0. Re-enabling starts a full BLANK period on digit 0.
- **Write to the shown digit:** `seg_out` updates on the next clk while in SHOW. The scan timing is not disturbed.

## Timing
- **Reset (async assert):** `seg_out` = 0, `dig_en` = 0, `frame_err` = 0. Digit registers are 0x00 and control is 0x01. FSM is in BLANK, d = 0, counter = 0. Deassertion is used synchronously via the normal flop path.
- **First SHOW:** digit 0 is first shown BLANK_CYCLES cycles after reset release.
- **Scan period:** NUM_DIGITS × (BLANK_CYCLES + SCAN_DIV) cycles.
- **SPI-to-register latency:** 3 clk cycles from the raw 16th sck rising edge to the register update. Made up of 2 sync cycles plus the commit cycle. Output reflects the new value 1 cycle later.
- **`frame_err` timing:** asserted for exactly 1 cycle, 3 cycles after the raw cs_n rise (short frame) or at commit time (bad address).
- **SPI clock limit:** sck high and low phases must each be ≥3 clk cycles. Faster sck is unsupported.
- **Reset mid-frame or mid-scan:** everything returns to reset values immediately. A partially shifted frame is lost without `frame_err`.

## Configuration
- **`SEG_HEX_DECODE_EN` defined:** when ctrl bit1 = 1, `seg_out[6:0]` is the hex decode of pattern[3:0] (0-F, standard a-g shapes) and `seg_out[7]` = pattern[7]. When bit1 = 0, the pattern is output raw.
- **Not defined:** the decoder is not built, ctrl bit1 is stored but ignored, and the output is always raw.

## Test plan
Bench parameters: NUM_DIGITS=4, SCAN_DIV=20, BLANK_CYCLES=4, sck half-period 4 clk.
- **Reset then idle:** release rst_n -> `dig_en` = 0 for 4 cycles, then 0001 for 20 cycles, then 0 for 4 cycles, then 0010. Full period is 96 cycles and returns to 0001. `seg_out` = 0 throughout.
- **Raw write:** write frame 0x02,0xA5 -> 3 cycles after the 16th sck, reg2 = 0xA5. While `dig_en` = 0100, `seg_out` = 0xA5. Other digits show 0x00.
- **Errors:** a frame to addr 0x07 -> `frame_err` pulses once and no register changes. An 8-bit frame then cs_n high -> `frame_err` pulses once. A 24-bit frame 0x01,0x3C,0xFF -> reg1 = 0x3C and no error.
- **Disable/enable:** write 0x10,0x00 -> outputs go 0 and stay 0 for 200 cycles. Write 0x10,0x01 -> 4 BLANK cycles, then `dig_en` = 0001.
- **Hex decode** (with `SEG_HEX_DECODE_EN`): write 0x10,0x03 and 0x00,0x88 -> digit 0 shows `seg_out` = 0xFF ("8" plus dp). Without the macro -> `seg_out` = 0x88.
- **Async reset mid-SHOW and mid-frame:** assert rst_n low on digit 2 SHOW with 9 bits shifted -> outputs go 0 immediately and registers return to reset values. After release, no `frame_err` and the scan restarts at digit 0.
